// File: rtl/cliff_pkg.sv
// Shared encodings, limits and helpers for the cliff game round controller.
package cliff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  localparam logic [1:0] SPEED_MAX     = 2'd2;
  localparam logic [3:0] STARTING_IDX  = 4'd7;
  localparam logic [3:0] POS_MIN_NUDGE = 4'd1;
  localparam logic [3:0] POS_MAX_NUDGE = 4'd14;

  // Wide enough for the slowest step period (50M cycles).
  localparam int CNT_W = 26;

  // Speed update from button pulses: up wins over down, both saturate.
  function automatic logic [1:0] adj_speed(input logic [1:0] s, input logic up, input logic dn);
    if (up)      return (s >= SPEED_MAX) ? SPEED_MAX : s + 2'd1;
    else if (dn) return (s == 2'd0) ? 2'd0 : s - 2'd1;
    else         return s;
  endfunction

endpackage

// File: rtl/cliff_tick_div.sv
// Programmable clock-enable divider: counts 0..period-1 while enabled and
// flags the terminal count combinationally; clr forces the count back to 0.
module cliff_tick_div
  import cliff_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt_q;

  // >= rather than == so a shortened period takes effect without overshooting.
  assign tick = en && (cnt_q >= period - W'(1));

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (en)   cnt_q <= tick ? '0 : cnt_q + W'(1);
  end

endmodule

// File: rtl/cliff_game_sched.sv
// Round controller for the cliff game people shifter (IDLE/RUN/LOSE).
// Optional automatic speed-up in RUN is enabled by defining CLIFF_AUTOSPEED_EN.
module cliff_game_sched
  import cliff_pkg::*;
#(
  parameter int TICK_SLOW = 50000000,
  parameter int TICK_MED  = 12500000,
  parameter int TICK_FAST = 5000000,
  parameter int BLINK_DIV = 5000000
`ifdef CLIFF_AUTOSPEED_EN
  , parameter int AUTO_STEPS = 16
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_p,
  input  logic       left_p,
  input  logic       right_p,
  input  logic       up_p,
  input  logic       down_p,
  input  logic [3:0] pos,
  input  logic [2:0] lim_hi,
  input  logic [2:0] lim_lo,
  output logic       load,
  output logic       clear,
  output logic       step_en,
  output logic       step_left,
  output logic [1:0] state,
  output logic [1:0] speed,
  output logic [1:0] dir,
  output logic       flash
);

  state_t           state_q, state_n;
  dir_t             dir_q, dir_n;
  logic [1:0]       speed_q, speed_n;
  logic             flash_q, flash_n;
  logic             load_n, clear_n, step_en_n, step_left_n;
  logic [CNT_W-1:0] step_period;
  logic             step_tick, blink_tick, lose_hit;

  always_comb begin
    case (speed_q)
      2'd0:    step_period = CNT_W'(TICK_SLOW);
      2'd1:    step_period = CNT_W'(TICK_MED);
      default: step_period = CNT_W'(TICK_FAST);
    endcase
  end

  cliff_tick_div #(.W(CNT_W)) u_step_div (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state_q == ST_RUN),
    .clr    (state_q != ST_RUN),
    .period (step_period),
    .tick   (step_tick)
  );

  cliff_tick_div #(.W(CNT_W)) u_blink_div (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state_q == ST_LOSE),
    .clr    (state_q != ST_LOSE),
    .period (CNT_W'(BLINK_DIV)),
    .tick   (blink_tick)
  );

  // 5-bit compare keeps 15-lim_hi from wrapping.
  assign lose_hit = ({1'b0, pos} >= (5'd15 - {2'b00, lim_hi})) ||
                    ({1'b0, pos} <= {2'b00, lim_lo});

`ifdef CLIFF_AUTOSPEED_EN
  localparam int SC_W = $clog2(AUTO_STEPS + 1);
  logic [SC_W-1:0] steps_q, steps_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) steps_q <= '0;
    else          steps_q <= steps_n;
  end
`endif

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_n     = state_q;
    speed_n     = speed_q;
    dir_n       = dir_q;
    flash_n     = flash_q;
    load_n      = 1'b0;
    clear_n     = 1'b0;
    step_en_n   = 1'b0;
    step_left_n = 1'b0;
`ifdef CLIFF_AUTOSPEED_EN
    steps_n     = steps_q;
`endif
    case (state_q)
      ST_IDLE: begin
        speed_n = adj_speed(speed_q, up_p, down_p);
        if (start_p) begin
          state_n = ST_RUN;
          dir_n   = DIR_NONE;
`ifdef CLIFF_AUTOSPEED_EN
          steps_n = '0;
`endif
        end else if (left_p) begin
          if (pos < POS_MAX_NUDGE) begin
            step_en_n   = 1'b1;
            step_left_n = 1'b1;
          end
        end else if (right_p && (pos > POS_MIN_NUDGE)) begin
          step_en_n = 1'b1;
        end
      end
      ST_RUN: begin
        if (start_p) begin
          state_n = ST_IDLE;
          load_n  = 1'b1;
          speed_n = 2'd0;
          dir_n   = DIR_NONE;
        end else if (lose_hit) begin
          state_n = ST_LOSE;
          clear_n = 1'b1;
        end else begin
          if (left_p)       dir_n = DIR_LEFT;
          else if (right_p) dir_n = DIR_RIGHT;
          speed_n = adj_speed(speed_q, up_p, down_p);
          if (step_tick && (dir_q != DIR_NONE)) begin
            step_en_n   = 1'b1;
            step_left_n = (dir_q == DIR_LEFT);
`ifdef CLIFF_AUTOSPEED_EN
            // A button press in the same cycle overrides the automatic bump.
            if (steps_q == SC_W'(AUTO_STEPS - 1)) begin
              steps_n = '0;
              if (!(up_p || down_p)) speed_n = adj_speed(speed_q, 1'b1, 1'b0);
            end else begin
              steps_n = steps_q + SC_W'(1);
            end
`endif
          end
        end
      end
      ST_LOSE: begin
        if (blink_tick) flash_n = ~flash_q;
        if (start_p) begin
          state_n = ST_IDLE;
          load_n  = 1'b1;
          speed_n = 2'd0;
          dir_n   = DIR_NONE;
          flash_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      speed_q   <= 2'd0;
      dir_q     <= DIR_NONE;
      flash_q   <= 1'b0;
      load      <= 1'b1;
      clear     <= 1'b0;
      step_en   <= 1'b0;
      step_left <= 1'b0;
    end else begin
      state_q   <= state_n;
      speed_q   <= speed_n;
      dir_q     <= dir_n;
      flash_q   <= flash_n;
      load      <= load_n;
      clear     <= clear_n;
      step_en   <= step_en_n;
      step_left <= step_left_n;
    end
  end

  assign state = state_q;
  assign speed = speed_q;
  assign dir   = dir_q;
  assign flash = flash_q;

endmodule

// File: tb/tb_cliff_game_sched.sv
// Self-checking bench for cliff_game_sched: directed scenarios plus random
// button traffic, all compared every cycle against a behavioural round model.
module tb_cliff_game_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_p = 1'b0, left_p = 1'b0, right_p = 1'b0, up_p = 1'b0, down_p = 1'b0;
  logic [3:0] pos = 4'd7;
  logic [2:0] lim_hi = 3'd0, lim_lo = 3'd0;
  logic       load, clear, step_en, step_left, flash;
  logic [1:0] state, speed, dir;

  localparam int AUTO = 4;

  cliff_game_sched #(
    .TICK_SLOW(8), .TICK_MED(4), .TICK_FAST(2), .BLINK_DIV(3)
`ifdef CLIFF_AUTOSPEED_EN
    , .AUTO_STEPS(AUTO)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_p(start_p), .left_p(left_p),
    .right_p(right_p), .up_p(up_p), .down_p(down_p), .pos(pos),
    .lim_hi(lim_hi), .lim_lo(lim_lo), .load(load), .clear(clear),
    .step_en(step_en), .step_left(step_left), .state(state), .speed(speed),
    .dir(dir), .flash(flash)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: round phase, cycles elapsed in the current step/blink
  // interval, and the registered command outputs expected after each edge.
  int m_state, m_speed, m_dir, m_flash, m_age, m_bage, m_steps;
  int m_load, m_clear, m_step, m_left;

  function automatic int period_of(input int sp);
    return (sp == 0) ? 8 : (sp == 1) ? 4 : 2;
  endfunction

  function automatic int bump(input int sp, input bit u, input bit d);
    if (u) return (sp < 2) ? sp + 1 : 2;
    if (d) return (sp > 0) ? sp - 1 : 0;
    return sp;
  endfunction

  task automatic model_reset();
    m_state = 0; m_speed = 0; m_dir = 0; m_flash = 0;
    m_age = 0; m_bage = 0; m_steps = 0;
    m_load = 1; m_clear = 0; m_step = 0; m_left = 0;
  endtask

  task automatic model_clock(input bit s, input bit l, input bit r, input bit u, input bit d);
    int ns, nsp, nd, nf, nst, nage, nbage;
    bit ld, cl, se, sl, lose, tick, btick;
    ns = m_state; nsp = m_speed; nd = m_dir; nf = m_flash; nst = m_steps;
    nage = 0; nbage = 0; ld = 0; cl = 0; se = 0; sl = 0;
    lose  = (int'(pos) >= 15 - int'(lim_hi)) || (int'(pos) <= int'(lim_lo));
    tick  = (m_age >= period_of(m_speed) - 1);
    btick = (m_bage >= 2);
    case (m_state)
      0: begin
        nsp = bump(m_speed, u, d);
        if (s) begin ns = 1; nd = 0; nst = 0; end
        else if (l) begin if (pos <= 13) begin se = 1; sl = 1; end end
        else if (r && pos >= 2) se = 1;
      end
      1: begin
        nage = tick ? 0 : m_age + 1;
        if (s) begin ns = 0; ld = 1; nsp = 0; nd = 0; end
        else if (lose) begin ns = 2; cl = 1; end
        else begin
          if (l) nd = 1; else if (r) nd = 2;
          nsp = bump(m_speed, u, d);
          if (tick && m_dir != 0) begin
            se = 1; sl = (m_dir == 1);
`ifdef CLIFF_AUTOSPEED_EN
            nst = m_steps + 1;
            if (nst == AUTO) begin
              nst = 0;
              if (!(u || d)) nsp = bump(m_speed, 1, 0);
            end
`endif
          end
        end
      end
      default: begin
        nbage = btick ? 0 : m_bage + 1;
        if (btick) nf = 1 - m_flash;
        if (s) begin ns = 0; ld = 1; nsp = 0; nd = 0; nf = 0; end
      end
    endcase
    m_state = ns; m_speed = nsp; m_dir = nd; m_flash = nf; m_steps = nst;
    m_age = nage; m_bage = nbage;
    m_load = ld; m_clear = cl; m_step = se; m_left = sl;
  endtask

  task automatic compare_all();
    check("load", load, m_load);
    check("clear", clear, m_clear);
    check("step_en", step_en, m_step);
    check("step_left", step_left, m_left);
    check("state", state, m_state);
    check("speed", speed, m_speed);
    check("dir", dir, m_dir);
    check("flash", flash, m_flash);
  endtask

  // One clock: drive pulses, advance the model at the edge, compare at negedge.
  task automatic cyc(input bit s = 0, input bit l = 0, input bit r = 0,
                     input bit u = 0, input bit d = 0);
    start_p = s; left_p = l; right_p = r; up_p = u; down_p = d;
    @(posedge clk);
    model_clock(s, l, r, u, d);
    @(negedge clk);
    start_p = 0; left_p = 0; right_p = 0; up_p = 0; down_p = 0;
    compare_all();
  endtask

  int n;
  int budget;
  int exp_speed;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_load", load, 1);
    compare_all();
    reset_n = 1'b1;
    cyc();
    check("rel_load", load, 0);

    // IDLE nudges
    pos = 4'd7; cyc(.l(1));
    check("idle_step", step_en, 1);
    check("idle_dirleft", step_left, 1);
    pos = 4'd14; cyc(.l(1));
    check("idle_edge_left", step_en, 0);
    pos = 4'd1; cyc(.r(1));
    check("idle_edge_right", step_en, 0);

    // RUN at slow speed, then fast
    pos = 4'd7;
    cyc(.s(1));
    cyc(.r(1));
    n = 0;
    repeat (32) begin cyc(); n += int'(step_en); end
`ifndef CLIFF_AUTOSPEED_EN
    check("slow_steps", n, 4);
`endif
    cyc(.u(1)); cyc(.u(1));
    check("speed_fast", speed, 2);
    n = 0;
    repeat (16) begin cyc(); n += int'(step_en); end
    check("fast_steps", n, 8);
    cyc(.u(1));
    check("speed_sat", speed, 2);

    // Lose on right cliff, blink, restart
    lim_lo = 3'd2; pos = 4'd3; cyc();
    pos = 4'd2; cyc();
    check("lose_state", state, 2);
    check("lose_clear", clear, 1);
    check("lose_nostep", step_en, 0);
    repeat (3) cyc();
    check("flash_on", flash, 1);
    repeat (3) cyc();
    check("flash_off", flash, 0);
    cyc(.s(1));
    check("restart_state", state, 0);
    check("restart_load", load, 1);

    // Abort beats lose
    lim_lo = 3'd0; pos = 4'd7; cyc(.s(1));
    lim_lo = 3'd2; pos = 4'd2; cyc(.s(1));
    check("abort_state", state, 0);
    check("abort_noclear", clear, 0);

    // Simultaneous buttons
    lim_lo = 3'd0; pos = 4'd7; cyc(.s(1));
    cyc(.l(1), .r(1));
    check("left_wins", dir, 1);
    cyc(.u(1));
    cyc(.u(1), .d(1));
    check("up_wins", speed, 2);

    // Automatic speed-up (or its absence)
    cyc(.s(1)); cyc(.s(1)); cyc(.l(1));
    n = 0; budget = 0;
    while (n < 4 && budget < 100) begin cyc(); n += int'(step_en); budget++; end
    check("auto_four_steps", n, 4);
`ifdef CLIFF_AUTOSPEED_EN
    exp_speed = 1;
`else
    exp_speed = 0;
`endif
    check("auto_speed1", speed, exp_speed);
    n = 0; budget = 0;
    while (n < 8 && budget < 100) begin cyc(); n += int'(step_en); budget++; end
    check("auto_eight_steps", n, 8);
`ifdef CLIFF_AUTOSPEED_EN
    exp_speed = 2;
`endif
    repeat (20) cyc();
    check("auto_speed2", speed, exp_speed);

    // Random traffic with an asynchronous reset midway
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 20 == 0) pos = 4'($urandom % 16);
      else                    pos = 4'(4 + $urandom % 8);
      if ($urandom % 100 == 0) begin
        lim_hi = 3'($urandom % 3);
        lim_lo = 3'($urandom % 3);
      end
      cyc(.s($urandom % 40 == 0), .l($urandom % 8 == 0), .r($urandom % 8 == 0),
          .u($urandom % 16 == 0), .d($urandom % 16 == 0));
      if (i == 750) begin
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_load", load, 1);
        check("async_state", state, 0);
        @(negedge clk);
        compare_all();
        reset_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cliff_game_sched.md
Name: cliff_game_sched

Overview:
Round controller for the cliff game people-shifter datapath. Replaces free-running variable clocks with single-clock enables and sequences the shifter through idle/run/lose phases. It takes debounced button pulses and switch limits, and issues load/clear/step commands plus display status. It sits between the button debouncers and the people/position register block.

Parameters:
TICK_SLOW, 50000000, clk cycles per step at speed 0
TICK_MED, 12500000, clk cycles per step at speed 1
TICK_FAST, 5000000, clk cycles per step at speed 2
BLINK_DIV, 5000000, clk cycles per flash toggle in LOSE
AUTO_STEPS, 16, RUN steps per automatic speed increment (optional feature only)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
start_p  in  1  debounced centre-button pulse, one cycle
left_p  in  1  debounced left pulse, one cycle
right_p  in  1  debounced right pulse, one cycle
up_p  in  1  debounced speed-up pulse
down_p  in  1  debounced speed-down pulse
pos  in  4  current person index from datapath (0..15)
lim_hi  in  3  left cliff width (sw[15:13])
lim_lo  in  3  right cliff width (sw[2:0])
load  out  1  one-cycle pulse: datapath reloads start pattern, pos=7
clear  out  1  one-cycle pulse: datapath clears people, pos=0
step_en  out  1  one-cycle pulse: datapath shifts one place
step_left  out  1  direction qualifying step_en (1 = shift left, pos+1)
state  out  2  0 IDLE, 1 RUN, 2 LOSE
speed  out  2  0..2
dir  out  2  0 none, 1 left, 2 right
flash  out  1  LED blink level in LOSE

Behaviour:
- All outputs registered. During reset: state=IDLE, speed=0, dir=0, flash=0, load=1 (held while reset_n low; deasserts on first clk after release), clear=0, step_en=0, step_left=0, tick counter=0.
- IDLE:
  - left_p/right_p -> step_en=1 next cycle, step_left=left_p.
  - Suppressed if left and pos>=14, or right and pos<=1.
  - dir stays 0. up_p/down_p still adjust speed.
  - start_p -> RUN; tick counter=0; dir=0.
- RUN:
  - Tick counter counts 0..period(speed)-1. At terminal count: counter->0, and if dir!=0, step_en=1 next cycle with step_left=(dir==1).
  - left_p sets dir=1; right_p sets dir=2; both in the same cycle -> left wins.
  - up_p: speed+1, saturating at 2. down_p: speed-1, saturating at 0. Both in the same cycle -> up wins.
  - Speed change takes effect immediately. If counter >= new period-1, it is treated as terminal count on the next cycle.
- Lose check, evaluated every cycle in RUN: pos >= 15-lim_hi or pos <= lim_lo. All arithmetic is 5-bit unsigned, so no wrap.
  - True -> LOSE next cycle, clear=1 for one cycle, and any step_en that cycle is suppressed (lose beats step).
- LOSE:
  - flash toggles every BLINK_DIV cycles, starting from 0.
  - Buttons other than start_p are ignored.
  - start_p -> IDLE, load=1, speed=0, dir=0, flash=0.
- start_p in RUN (abort) -> IDLE, load=1, speed=0, dir=0.
  - start_p beats the lose check in the same cycle.
- Only one of load/clear/step_en is ever high in a cycle. Priority: load > clear > step_en.
- reset_n asserted mid-round forces reset values asynchronously, whatever the state.

Optional Feature:
CLIFF_AUTOSPEED_EN
- Defined: a RUN step counter increments on each issued step_en. At AUTO_STEPS it resets and speed increments, saturating at 2. The counter is cleared on entry to RUN. A button change on the same cycle wins over the auto increment.
- Undefined: the step counter is not instantiated and speed changes only via up_p/down_p.

Decomposition:
- Package cliff_pkg holds:
  - state encodings (IDLE/RUN/LOSE) and dir encodings (NONE/LEFT/RIGHT);
  - SPEED_MAX=2, STARTING_IDX=7, POS_MIN_NUDGE=1, POS_MAX_NUDGE=14.
- Sub-module cliff_tick_div: programmable clock-enable divider with period input, sync clear and terminal pulse. It is instantiated twice, for the step tick and the flash blink.

Test Plan (TICK_SLOW=8, TICK_MED=4, TICK_FAST=2, BLINK_DIV=3):
- Reset release -> load held during reset then deasserts; state=0, speed=0, dir=0. IDLE left_p with pos=7 -> one step_en, step_left=1. left_p with pos=14 -> no step_en.
- start_p, then right_p, speed 0 -> step_en every 8 cycles with step_left=0. up_p twice -> speed=2, step_en every 2 cycles. Third up_p -> speed stays 2.
- RUN with lim_lo=2 and pos driven 3->2 -> state=2 one cycle later, single clear pulse, no step_en that cycle. flash toggles every 3 cycles.
- LOSE, start_p -> state=0, load pulse, speed=0, dir=0. start_p during RUN the same cycle lose is true -> IDLE/load, no clear.
- left_p and right_p same cycle in RUN -> dir=1. up_p and down_p same cycle at speed 1 -> speed=2.
- With CLIFF_AUTOSPEED_EN, AUTO_STEPS=4: 4 steps at speed 0 -> speed=1; 8 more steps -> speed=2 and stays. Without the macro, speed stays 0.
